// File: rtl/array_fifo_pkg.sv
// Shared constants and payload type for the array-backed FIFO controller.
package array_fifo_pkg;

    localparam int WIDTH  = 160;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 3);

    typedef logic [WIDTH-1:0] payload_t;

endpackage

// File: rtl/array_fifo_outbuf.sv
// Two-entry in-order output buffer; absorbs the one-cycle read latency of the RAM macro.
module array_fifo_outbuf #(
    parameter int WIDTH = 160
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] tail_reg;
    logic [1:0]       count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_reg == 2'd0) head_reg <= push_data;
                    else                   tail_reg <= push_data;
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    head_reg  <= tail_reg;
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever survives the pop.
                    if (count_reg == 2'd1) begin
                        head_reg <= push_data;
                    end else begin
                        head_reg <= tail_reg;
                        tail_reg <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = head_reg;

endmodule

// File: rtl/array_7_fifo_ctrl.sv
// Ready/valid FIFO controller driving an external 1W1R RAM macro with registered read.
// Define ARRAY_FIFO_BYPASS_EN to route enqueues straight to the output buffer when the FIFO is empty.
module array_7_fifo_ctrl
    import array_fifo_pkg::*;
#(
    parameter int WIDTH  = array_fifo_pkg::WIDTH,
    parameter int DEPTH  = array_fifo_pkg::DEPTH,
    parameter int ADDR_W = array_fifo_pkg::ADDR_W,
    parameter int CNT_W  = array_fifo_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_enq_valid,
    output logic              io_enq_ready,
    input  logic [WIDTH-1:0]  io_enq_bits,
    output logic              io_deq_valid,
    input  logic              io_deq_ready,
    output logic [WIDTH-1:0]  io_deq_bits,
    output logic [CNT_W-1:0]  io_count,
    output logic [ADDR_W-1:0] ram_W0_addr,
    output logic              ram_W0_en,
    output logic [WIDTH-1:0]  ram_W0_data,
    output logic [ADDR_W-1:0] ram_R0_addr,
    output logic              ram_R0_en,
    input  logic [WIDTH-1:0]  ram_R0_data
);

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]  ram_cnt_reg;
    logic              inflight_reg;

    logic [1:0]        ob_cnt;
    logic [WIDTH-1:0]  ob_head;
    logic [2:0]        ob_pending;
    logic              enq_fire;
    logic              deq_fire;
    logic              issue;
    logic              bypass;
    logic              wr_en;
    logic              ob_push;
    logic [WIDTH-1:0]  ob_push_data;

    assign io_enq_ready = (ram_cnt_reg != CNT_W'(DEPTH));
    assign io_deq_valid = (ob_cnt != 2'd0);
    assign enq_fire     = io_enq_valid & io_enq_ready;
    assign deq_fire     = io_deq_valid & io_deq_ready;

    // Words the output buffer will be committed to after this cycle, not counting a new issue.
    assign ob_pending = {1'b0, ob_cnt} + {2'b00, inflight_reg} - {2'b00, deq_fire};
    assign issue      = (ram_cnt_reg != '0) && (ob_pending < 3'd2);

`ifdef ARRAY_FIFO_BYPASS_EN
    assign bypass = enq_fire && (ram_cnt_reg == '0) && !inflight_reg && (ob_pending < 3'd2);
`else
    assign bypass = 1'b0;
`endif

    assign wr_en        = enq_fire & ~bypass;
    assign ob_push      = inflight_reg | bypass;
    assign ob_push_data = inflight_reg ? ram_R0_data : io_enq_bits;

    assign ram_W0_en   = wr_en;
    assign ram_W0_addr = wr_ptr_reg;
    assign ram_W0_data = io_enq_bits;
    assign ram_R0_en   = issue;
    assign ram_R0_addr = rd_ptr_reg;

    assign io_count = ram_cnt_reg + CNT_W'(inflight_reg) + CNT_W'(ob_cnt);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ram_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            if (issue) rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            ram_cnt_reg  <= ram_cnt_reg + CNT_W'(wr_en) - CNT_W'(issue);
            inflight_reg <= issue;
        end
    end

    array_fifo_outbuf #(
        .WIDTH(WIDTH)
    ) u_outbuf (
        .clock     (clock),
        .reset     (reset),
        .push      (ob_push),
        .push_data (ob_push_data),
        .pop       (deq_fire),
        .count     (ob_cnt),
        .head      (ob_head)
    );

    assign io_deq_bits = ob_head;

endmodule

// File: tb/tb_array_7_fifo_ctrl.sv
// Scoreboard bench for array_7_fifo_ctrl with a behavioural RAM macro; honours ARRAY_FIFO_BYPASS_EN.
module tb_array_7_fifo_ctrl;
    import array_fifo_pkg::*;

`ifdef ARRAY_FIFO_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              io_enq_valid;
    logic              io_enq_ready;
    payload_t          io_enq_bits;
    logic              io_deq_valid;
    logic              io_deq_ready;
    payload_t          io_deq_bits;
    logic [CNT_W-1:0]  io_count;
    logic [ADDR_W-1:0] ram_W0_addr;
    logic              ram_W0_en;
    payload_t          ram_W0_data;
    logic [ADDR_W-1:0] ram_R0_addr;
    logic              ram_R0_en;
    payload_t          ram_R0_data;

    always #5 clock = ~clock;

    array_7_fifo_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .io_enq_valid (io_enq_valid),
        .io_enq_ready (io_enq_ready),
        .io_enq_bits  (io_enq_bits),
        .io_deq_valid (io_deq_valid),
        .io_deq_ready (io_deq_ready),
        .io_deq_bits  (io_deq_bits),
        .io_count     (io_count),
        .ram_W0_addr  (ram_W0_addr),
        .ram_W0_en    (ram_W0_en),
        .ram_W0_data  (ram_W0_data),
        .ram_R0_addr  (ram_R0_addr),
        .ram_R0_en    (ram_R0_en),
        .ram_R0_data  (ram_R0_data)
    );

    // RAM macro model: registered read, read-before-write on a shared edge.
    payload_t mem [DEPTH];
    always @(posedge clock) begin
        if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;
        if (ram_R0_en) ram_R0_data <= mem[ram_R0_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input payload_t act, input payload_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard state
    payload_t          exp_q[$];
    int                count_model = 0;
    int                ram_model   = 0;
    int                max_count   = 0;
    logic [ADDR_W-1:0] wr_model    = '0;
    logic [ADDR_W-1:0] rd_model    = '0;
    logic [DEPTH-1:0]  busy        = '0;

    always @(negedge clock) begin
        if (!reset && io_enq_valid && io_enq_ready) exp_q.push_back(io_enq_bits);
    end

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            count_model = 0;
            ram_model   = 0;
            wr_model    = '0;
            rd_model    = '0;
            busy        = '0;
        end else begin
            automatic bit ef = io_enq_valid && io_enq_ready;
            automatic bit df = io_deq_valid && io_deq_ready;
            check_int("io_count", int'(io_count), count_model);
            if (int'(io_count) > max_count) max_count = int'(io_count);
            if (ram_W0_en) begin
                check_int("w0_addr", int'(ram_W0_addr), int'(wr_model));
                check_int("w0_slot_free", int'(busy[ram_W0_addr]), 0);
            end
            if (ram_R0_en) begin
                check_int("r0_addr", int'(rd_model), int'(ram_R0_addr));
                check_int("r0_ram_nonempty", int'(ram_model != 0), 1);
                check_int("r0_ob_space", int'((count_model - ram_model - int'(df)) < 2), 1);
            end
            if (df) begin
                if (exp_q.size() == 0) check_int("deq_unexpected", 1, 0);
                else                   check_data("deq_bits", io_deq_bits, exp_q.pop_front());
            end
            if (ram_W0_en) begin
                busy[ram_W0_addr] = 1'b1;
                wr_model++;
                ram_model++;
            end
            if (ram_R0_en) begin
                busy[ram_R0_addr] = 1'b0;
                rd_model++;
                ram_model--;
            end
            count_model += int'(ef) - int'(df);
        end
    end

    // Samples handshakes before the edge, then returns just after it.
    task automatic step(output bit ef, output bit df);
        @(negedge clock);
        ef = io_enq_valid && io_enq_ready;
        df = io_deq_valid && io_deq_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values();
        check_int("rst_enq_ready", int'(io_enq_ready), 1);
        check_int("rst_deq_valid", int'(io_deq_valid), 0);
        check_data("rst_deq_bits", io_deq_bits, '0);
        check_int("rst_count", int'(io_count), 0);
        check_int("rst_w0_en", int'(ram_W0_en), 0);
        check_int("rst_r0_en", int'(ram_R0_en), 0);
        check_int("rst_w0_addr", int'(ram_W0_addr), 0);
        check_int("rst_r0_addr", int'(ram_R0_addr), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit       ef, df;
        int       lat, accepted, deqs, enqs, cycles;
        payload_t d;
        payload_t a5;
        payload_t one;

        a5  = {20{8'hA5}};
        one = payload_t'(1);
        d   = '0;
        io_enq_valid = 1'b0;
        io_enq_bits  = '0;
        io_deq_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clock);
        check_reset_values();
        @(posedge clock);
        #1 reset = 1'b0;

        // Single enqueue latency
        io_deq_ready = 1'b1;
        io_enq_bits  = a5;
        io_enq_valid = 1'b1;
        step(ef, df);
        io_enq_valid = 1'b0;
        lat = 1;
        while (!io_deq_valid && lat < 20) begin
            step(ef, df);
            lat++;
        end
        check_int("single_latency", lat, LAT);
        check_data("single_bits", io_deq_bits, a5);
        step(ef, df);
        check_int("single_count_empty", int'(io_count), 0);

        // Fill to full with the consumer stalled
        io_deq_ready = 1'b0;
        io_enq_valid = 1'b1;
        io_enq_bits  = d;
        accepted = 0;
        for (int i = 0; i < 100; i++) begin
            step(ef, df);
            if (ef) begin
                accepted++;
                d++;
                io_enq_bits = d;
            end
            if (!io_enq_ready) break;
        end
        check_int("fill_accepted", accepted, DEPTH + 2);
        check_int("fill_count", int'(io_count), DEPTH + 2);
        check_int("fill_enq_ready", int'(io_enq_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step(ef, df);
            check_int("full_blocks_enq", int'(ef), 0);
        end

        // Streaming from full: one dequeue per cycle, pointers wrap
        io_deq_ready = 1'b1;
        deqs = 0;
        for (int i = 0; i < 200; i++) begin
            step(ef, df);
            if (ef) begin
                d++;
                io_enq_bits = d;
            end
            if (df) deqs++;
        end
        check_int("stream_deq_per_cycle", deqs, 200);

        // Random handshakes
        enqs   = 0;
        cycles = 0;
        while (enqs < 10000 && cycles < 60000) begin
            io_enq_valid = 1'($urandom_range(0, 1));
            io_deq_ready = 1'($urandom_range(0, 1));
            step(ef, df);
            if (ef) begin
                enqs++;
                d++;
                io_enq_bits = d;
            end
            cycles++;
        end
        check_int("random_enqs", enqs, 10000);
        io_enq_valid = 1'b0;
        io_deq_ready = 1'b1;
        for (int i = 0; i < 200 && io_count != '0; i++) step(ef, df);
        check_int("drain_count", int'(io_count), 0);
        check_int("max_count_bound", int'(max_count <= DEPTH + 2), 1);

        // Reset with entries held and a read in flight
        io_deq_ready = 1'b0;
        io_enq_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 40 && accepted < 10; i++) begin
            step(ef, df);
            if (ef) begin
                accepted++;
                d++;
                io_enq_bits = d;
            end
        end
        io_enq_valid = 1'b0;
        repeat (5) step(ef, df);
        io_deq_ready = 1'b1;
        step(ef, df);
        reset = 1'b1;
        io_deq_ready = 1'b0;
        @(negedge clock);
        check_reset_values();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_int("post_rst_deq_valid", int'(io_deq_valid), 0);
        @(posedge clock);
        #1;
        io_enq_bits  = one;
        io_enq_valid = 1'b1;
        io_deq_ready = 1'b1;
        step(ef, df);
        io_enq_valid = 1'b0;
        for (int i = 0; i < 20 && !io_deq_valid; i++) step(ef, df);
        check_data("post_rst_first_bits", io_deq_bits, one);
        step(ef, df);
        check_int("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_7_fifo_ctrl.md
# array_7_fifo_ctrl

Ready/valid FIFO controller that drives a 64-entry × 160-bit 1W1R RAM macro with registered read address (read data appears one cycle after R0_en) and presents a decoupled dequeue port downstream. Sits directly upstream of the macro, generating its W0/R0 pins. A 2-entry output buffer hides the read latency so the controller sustains one enqueue and one dequeue per cycle.

## Interface
Parameters:
- WIDTH, 160, payload width
- DEPTH, 64, RAM entries; must be a power of two
- ADDR_W, 6, log2(DEPTH)
- CNT_W, 7, occupancy counter width; holds 0..DEPTH+2

Ports:
- Single clock; reset is asynchronous and active-high.
- clock  in  1  sole clock; also drives the macro W0_clk/R0_clk at the parent
- reset  in  1  asynchronous reset, active-high
- io_enq_valid  in  1  producer has data
- io_enq_ready  out  1  controller accepts data
- io_enq_bits  in  WIDTH  enqueue payload
- io_deq_valid  out  1  output buffer head valid
- io_deq_ready  in  1  consumer accepts
- io_deq_bits  out  WIDTH  output buffer head
- io_count  out  CNT_W  total entries held (RAM + in-flight read + output buffer)
- ram_W0_addr  out  ADDR_W  write address
- ram_W0_en  out  1  write enable
- ram_W0_data  out  WIDTH  write data
- ram_R0_addr  out  ADDR_W  read address
- ram_R0_en  out  1  read enable
- ram_R0_data  in  WIDTH  read data, valid the cycle after ram_R0_en

## Operation
- State: wr_ptr and rd_ptr (ADDR_W, wrap DEPTH-1→0 by natural overflow); ram_cnt (0..DEPTH); inflight (0/1); ob_cnt (0..2).
- io_enq_ready = (ram_cnt != DEPTH). No combinational path from io_deq_ready.
- enq fire (valid & ready), non-bypass: ram_W0_en=1, ram_W0_addr=wr_ptr, ram_W0_data=io_enq_bits; wr_ptr++, ram_cnt++.
- Read issue: ram_R0_en = (ram_cnt != 0) & (ob_cnt_next_free), where free means ob_cnt + inflight − deq_fire < 2. On issue: ram_R0_addr=rd_ptr, rd_ptr++, ram_cnt--, inflight←1.
- Cycle after issue: ram_R0_data is pushed into the output buffer unconditionally (space is guaranteed by issue rule); inflight←0 unless a new issue occurs.
- Output buffer: 2-entry in-order queue; io_deq_valid = ob_cnt != 0; io_deq_bits = head.
- Same-cycle enq and issue update ram_cnt by net zero; same-cycle push and deq_fire keep ob_cnt.
- Full: ram_cnt==DEPTH blocks enqueue even while io_deq_ready=1; ready returns the cycle after a read issue.
- Empty: ram_cnt==0 → no issue; deq_valid falls when ob_cnt reaches 0.
- Write/read same slot after wrap: slot is free only after its issue; the write commits at the end of the cycle in which stale read data is captured, so no hazard.
- io_count = ram_cnt + inflight + ob_cnt; max DEPTH+2.

## Timing
- Reset values: io_enq_ready=1, io_deq_valid=0, io_deq_bits=0, io_count=0, ram_W0_en=0, ram_R0_en=0, addresses 0, all pointers/counters 0, output buffer data 0.
- Reset asserted mid-operation: all contents discarded immediately; in-flight read data ignored on first cycle after deassert.
- Latency (no bypass): enq fire in cycle t → RAM write edge end of t → issue t+1 → data t+2 → io_deq_valid t+3.
- Throughput: one enq and one deq per cycle sustained once output buffer primed.

## Configuration
- ARRAY_FIFO_BYPASS_EN defined: when ram_cnt==0, inflight==0 and output buffer has space after this cycle's deq, enqueued data is pushed straight into the output buffer (no RAM write, ram_W0_en=0); io_deq_valid in t+1. Ordering preserved by the empty condition.
- Undefined: every enqueue goes through the RAM; latency fixed at 3 cycles.

## Structure
- Package array_fifo_pkg: WIDTH, DEPTH, ADDR_W, CNT_W constants and a payload typedef of WIDTH bits.
- Sub-module array_fifo_outbuf: 2-entry in-order output buffer with push/pop, count and head outputs.
- RAM macro instantiated by the parent, not inside this block.

## Test plan
- Reset then single enq 0xA5 (WIDTH-replicated) with deq_ready=1 → deq_valid at t+3 (t+1 with bypass), bits 0xA5, io_count back to 0.
- Enqueue 66 entries with deq_ready=0 → enq_ready drops after RAM holds 64 and io_count=66; ram_R0_en never fires with ob full.
- Full, then deq_ready=1 and enq_valid=1 continuously for 200 cycles with incrementing data → in-order output, one per cycle, pointers wrap 63→0 at least twice.
- Random valid/ready (50% each) 10k transactions → scoreboard match, io_count never exceeds 66, no write to an unread slot.
- Reset asserted with 10 entries held and a read in flight → all outputs at reset values next cycle; next enq 0x1 is first dequeued value.
